// File: rtl/corelet_ctrl_if.sv
// Corelet controller bus: tile request inputs, corelet instruction,
// SRAM strobes and status.
interface corelet_ctrl_if #(
    parameter int len_w  = 8,
    parameter int addr_w = 11
);
    logic              start;
    logic [len_w-1:0]  num_t;
    logic [addr_w-1:0] w_base;
    logic [addr_w-1:0] a_base;
    logic              o_valid;
    logic [7:0]        inst;
    logic              mem_rd;
    logic [addr_w-1:0] mem_addr;
    logic              psum_wr;
    logic [len_w-1:0]  psum_addr;
    logic              busy;
    logic              done;

    modport master (
        output start, num_t, w_base, a_base, o_valid,
        input  inst, mem_rd, mem_addr, psum_wr, psum_addr, busy, done
    );

    modport slave (
        input  start, num_t, w_base, a_base, o_valid,
        output inst, mem_rd, mem_addr, psum_wr, psum_addr, busy, done
    );
endinterface

// File: rtl/corelet_ctrl.sv
// Tile sequencer for one corelet: weight load, kernel load, activation
// load, execute, drain. Optional SFP pass under CORELET_CTRL_SFP_EN.
module corelet_ctrl #(
    parameter int row    = 8,
    parameter int col    = 8,
    parameter int len_w  = 8,
    parameter int addr_w = 11
) (
    input logic           clk,
    input logic           reset,
    corelet_ctrl_if.slave bus
);
    localparam int CW_A = len_w + 1;
    localparam int CW_B = $clog2(row + col + 2);
    localparam int CW   = (CW_A > CW_B) ? CW_A : CW_B;
    localparam logic [CW-1:0] C_ONE = CW'(1);

`ifdef CORELET_CTRL_SFP_EN
    typedef enum logic [3:0] {
        IDLE, LOAD_W, KLOAD, KGAP, LOAD_A, EXEC, DRAIN, SFP, DONE
    } state_t;
`else
    typedef enum logic [3:0] {
        IDLE, LOAD_W, KLOAD, KGAP, LOAD_A, EXEC, DRAIN, DONE
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [len_w-1:0]  t_q, t_d;
    logic [addr_w-1:0] wb_q, wb_d;
    logic [addr_w-1:0] ab_q, ab_d;
    logic [len_w-1:0]  rd_q, rd_d;
    logic [len_w-1:0]  wr_q, wr_d;
    logic [7:0]        inst_q, inst_d;
    logic              mem_rd_q, mem_rd_d;
    logic [addr_w-1:0] mem_addr_q, mem_addr_d;
    logic              psum_wr_q, psum_wr_d;
    logic [len_w-1:0]  psum_addr_q, psum_addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [CW-1:0]     t_ext;
    logic              rd_now;
    logic              last_wr;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        t_d     = t_q;
        wb_d    = wb_q;
        ab_d    = ab_q;
        t_ext   = CW'(t_q);
        rd_now  = (state_q == DRAIN) && bus.o_valid && (rd_q != t_q);
        last_wr = psum_wr_q && (wr_q == t_q - len_w'(1));
        rd_d    = (state_q == DRAIN) ? rd_q + len_w'(rd_now) : '0;
        wr_d    = (state_q == DRAIN) ? wr_q + len_w'(psum_wr_q) : '0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    t_d     = bus.num_t;
                    wb_d    = bus.w_base;
                    ab_d    = bus.a_base;
                    cnt_d   = '0;
                    state_d = (bus.num_t != '0) ? LOAD_W : DONE;
                end
            end
            LOAD_W: begin
                cnt_d = cnt_q + C_ONE;
                if (cnt_q == CW'(col)) begin
                    cnt_d   = '0;
                    state_d = KLOAD;
                end
            end
            KLOAD: begin
                cnt_d = cnt_q + C_ONE;
                if (cnt_q == CW'(col - 1)) begin
                    cnt_d   = '0;
                    state_d = KGAP;
                end
            end
            KGAP: begin
                cnt_d = cnt_q + C_ONE;
                if (cnt_q == CW'(row + col - 1)) begin
                    cnt_d   = '0;
                    state_d = LOAD_A;
                end
            end
            LOAD_A: begin
                cnt_d = cnt_q + C_ONE;
                if (cnt_q == t_ext) begin
                    cnt_d   = '0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                cnt_d = cnt_q + C_ONE;
                if (cnt_q == t_ext - C_ONE) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_wr) begin
                    cnt_d = '0;
`ifdef CORELET_CTRL_SFP_EN
                    state_d = SFP;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef CORELET_CTRL_SFP_EN
            SFP: begin
                cnt_d = cnt_q + C_ONE;
                if (cnt_q == t_ext - C_ONE) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered against the state being entered.
        inst_d     = '0;
        mem_rd_d   = 1'b0;
        mem_addr_d = '0;
        unique case (state_d)
            LOAD_W: begin
                mem_rd_d  = cnt_d < CW'(col);
                inst_d[2] = cnt_d != '0;
                if (mem_rd_d) mem_addr_d = wb_d + addr_w'(cnt_d);
            end
            LOAD_A: begin
                mem_rd_d  = cnt_d < CW'(t_d);
                inst_d[2] = cnt_d != '0;
                if (mem_rd_d) mem_addr_d = ab_d + addr_w'(cnt_d);
            end
            KLOAD: inst_d[3:0] = 4'b1001;
            EXEC:  inst_d[3:0] = 4'b1010;
`ifdef CORELET_CTRL_SFP_EN
            SFP:   inst_d[7] = 1'b1;
`endif
            default: ;
        endcase

        psum_wr_d   = rd_now;
        psum_addr_d = (state_d == DRAIN) ? wr_d : '0;
        busy_d      = state_d != IDLE;
        done_d      = state_d == DONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            t_q         <= '0;
            wb_q        <= '0;
            ab_q        <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            inst_q      <= '0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            psum_wr_q   <= 1'b0;
            psum_addr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            t_q         <= t_d;
            wb_q        <= wb_d;
            ab_q        <= ab_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            inst_q      <= inst_d;
            mem_rd_q    <= mem_rd_d;
            mem_addr_q  <= mem_addr_d;
            psum_wr_q   <= psum_wr_d;
            psum_addr_q <= psum_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // ofifo_rd follows o_valid in the same cycle so an empty FIFO is never read.
    assign bus.inst      = inst_q | {1'b0, rd_now, 6'b0};
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.psum_wr   = psum_wr_q;
    assign bus.psum_addr = psum_addr_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule
